// File: rtl/fpu_pkg.sv
// FP32 add/sub shared types.
// Field widths, exponent limits and stage payloads.
package fpu_pkg;

  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int SUM_W    = 28;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int XEXP_W   = EXP_W + 2;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef struct packed {
    logic                     special;
    logic [31:0]              special_data;
    logic                     sign;
    logic                     zero;
    logic                     uflow;
    logic signed [XEXP_W-1:0] exp;
    logic [SUM_W-2:0]         mant;
  } s1_t;

endpackage

// File: rtl/add_sub_lzc_28bit.sv
// Leading-zero count over the hidden..sticky bits of the raw sum.
// Seven 4-bit leaves, topmost nonzero leaf wins.
module add_sub_lzc_28bit (
  input  logic [26:0] i_bits,
  output logic [4:0]  o_count,
  output logic        o_zero
);

  logic [27:0]      pad;
  logic [6:0]       leaf_zero;
  logic [6:0][1:0]  leaf_cnt;

  function automatic logic [1:0] lz4(input logic [3:0] n);
    logic [1:0] c;
    casez (n)
      4'b1???: c = 2'd0;
      4'b01??: c = 2'd1;
      4'b001?: c = 2'd2;
      default: c = 2'd3;
    endcase
    return c;
  endfunction

  assign pad = {i_bits, 1'b0};

  for (genvar j = 0; j < 7; j++) begin : g_leaf
    logic [3:0] nib;
    assign nib          = pad[27-4*j -: 4];
    assign leaf_zero[j] = ~|nib;
    assign leaf_cnt[j]  = lz4(nib);
  end

  // pick the most significant nonzero leaf
  always_comb begin
    o_count = 5'd27;
    for (int j = 6; j >= 0; j--) begin
      if (!leaf_zero[j])
        o_count = 5'(4 * j) + {3'b0, leaf_cnt[j]};
    end
  end

  assign o_zero = &leaf_zero;

endmodule

// File: rtl/add_sub_normalize.sv
// FP32 add/sub normalize, RNE round and pack.
// Two register stages under one global stall.
module add_sub_normalize
  import fpu_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int SUM_W  = 28
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_sign,
  input  logic [EXP_W-1:0] i_exp,
  input  logic [SUM_W-1:0] i_mant,
  input  logic             i_special,
  input  logic [31:0]      i_special_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_data,
  output logic             o_zero,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam logic signed [XEXP_W-1:0] X_ONE = XEXP_W'(1);
  localparam logic signed [XEXP_W-1:0] X_MAX = XEXP_W'(EXP_MAX);

  logic                     en;
  logic                     v1;
  s1_t                      s1_d;
  s1_t                      s1_q;
  logic [4:0]               lz_cnt;
  logic                     lz_zero;
  logic                     sel_spec;
  logic                     sel_carry;
  logic                     sel_zero;
  logic                     sel_flush;
  logic signed [XEXP_W-1:0] xexp_in;
  logic signed [XEXP_W-1:0] xlz;

  assign en      = !o_valid | i_ready;
  assign o_ready = en;

  add_sub_lzc_28bit u_lzc (
    .i_bits  (i_mant[SUM_W-2:0]),
    .o_count (lz_cnt),
    .o_zero  (lz_zero)
  );

  assign xexp_in   = signed'({2'b0, i_exp});
  assign xlz       = signed'({{(EXP_W-3){1'b0}}, lz_cnt});
  assign sel_spec  = i_special;
  assign sel_carry = !i_special & i_mant[SUM_W-1];
  assign sel_zero  = !i_special & !i_mant[SUM_W-1] & lz_zero;
  assign sel_flush = !i_special & !i_mant[SUM_W-1] & !lz_zero
                   & ({2'b0, i_exp} <= {{(EXP_W-3){1'b0}}, lz_cnt});

  // stage 1: normalize the raw sum
  always_comb begin
    s1_d              = '0;
    s1_d.special_data = i_special_data;
    s1_d.sign         = i_sign;
    unique case (1'b1)
      sel_spec:  s1_d.special = 1'b1;
      sel_carry: begin
        s1_d.mant = {i_mant[SUM_W-1:2], |i_mant[1:0]};
        s1_d.exp  = xexp_in + X_ONE;
      end
      sel_zero: begin
        s1_d.sign = 1'b0;
        s1_d.zero = 1'b1;
      end
      sel_flush: begin
        s1_d.zero  = 1'b1;
        s1_d.uflow = 1'b1;
      end
      default: begin
        s1_d.mant = i_mant[SUM_W-2:0] << lz_cnt;
        s1_d.exp  = xexp_in - xlz;
      end
    endcase
  end

  // stage 1 register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1   <= 1'b0;
      s1_q <= '0;
    end else if (en) begin
      v1 <= i_valid;
      if (i_valid) s1_q <= s1_d;
    end
  end

  logic                     g;
  logic                     r;
  logic                     s;
  logic                     lsb;
  logic                     rnd;
  logic                     ovf;
  logic [FRAC_W:0]          frac_r;
  logic signed [XEXP_W-1:0] exp_r;
  fp32_t                    res;
  logic                     r_zero;
  logic                     r_of;
  logic                     r_uf;

  // stage 2: round to nearest even and pack
  always_comb begin
    {lsb, g, r, s} = s1_q.mant[3:0];
    rnd    = g & (r | s | lsb);
    frac_r = {1'b0, s1_q.mant[SUM_W-3:3]}
           + {{FRAC_W{1'b0}}, rnd};
    exp_r  = s1_q.exp
           + {{(XEXP_W-1){1'b0}}, frac_r[FRAC_W]};
    ovf    = !s1_q.special & !s1_q.zero & (exp_r >= X_MAX);
    res    = '0;
    r_zero = 1'b0;
    r_of   = 1'b0;
    r_uf   = 1'b0;
    unique case (1'b1)
      s1_q.special: res = s1_q.special_data;
      s1_q.zero: begin
        res.sign = s1_q.sign;
        r_zero   = 1'b1;
        r_uf     = s1_q.uflow;
      end
      ovf: begin
        res.sign = s1_q.sign;
        res.exp  = '1;
        r_of     = 1'b1;
      end
      default: begin
        res.sign = s1_q.sign;
        res.exp  = exp_r[EXP_W-1:0];
        res.frac = frac_r[FRAC_W-1:0];
      end
    endcase
  end

  // stage 2 register drives the outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_zero      <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (en) begin
      o_valid <= v1;
      if (v1) begin
        o_data      <= res;
        o_zero      <= r_zero;
        o_overflow  <= r_of;
        o_underflow <= r_uf;
      end
    end
  end

endmodule

// File: tb/tb_add_sub_normalize.sv
// Bench for add_sub_normalize: directed vectors, stall,
// reset mid-stream and random beats against an arithmetic model.
module tb_add_sub_normalize;

  logic        clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic        i_sign;
  logic [7:0]  i_exp;
  logic [27:0] i_mant;
  logic        i_special;
  logic [31:0] i_special_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic        o_zero;
  logic        o_overflow;
  logic        o_underflow;

  int checks = 0;
  int errors = 0;
  logic [34:0] exp_q[$];
  bit          stalled = 0;
  logic [34:0] held;
  bit          done;

  add_sub_normalize dut (
    .i_clk          (clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_sign         (i_sign),
    .i_exp          (i_exp),
    .i_mant         (i_mant),
    .i_special      (i_special),
    .i_special_data (i_special_data),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_data         (o_data),
    .o_zero         (o_zero),
    .o_overflow     (o_overflow),
    .o_underflow    (o_underflow)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [34:0] obs,
                     input logic [34:0] ex);
    checks++;
    assert (obs === ex) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, ex);
    end
  endtask

  // result {data, zero, overflow, underflow} from value arithmetic
  function automatic logic [34:0] model(logic s, logic [7:0] e,
      logic [27:0] m, logic sp, logic [31:0] spd);
    int msb;
    int sh;
    int ex;
    longint q;
    longint rem;
    longint half;
    if (sp) return {spd, 3'b000};
    if (m == 0) return {32'h0, 3'b100};
    msb = 0;
    for (int i = 0; i < 28; i++) if (m[i]) msb = i;
    if (msb <= 26 && int'(e) <= 26 - msb) return {s, 31'h0, 3'b101};
    ex = int'(e) + msb - 26;
    sh = msb - 23;
    if (sh > 0) begin
      q    = longint'(m) >> sh;
      rem  = longint'(m) & ((64'sd1 << sh) - 1);
      half = 64'sd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end else begin
      q = longint'(m) << (-sh);
    end
    if (q == (64'sd1 << 24)) begin
      q  = q >> 1;
      ex = ex + 1;
    end
    if (ex >= 255) return {s, 8'hFF, 23'h0, 3'b010};
    return {s, 8'(ex), q[22:0], 3'b000};
  endfunction

  task automatic send_exp(input logic s, input logic [7:0] e,
      input logic [27:0] m, input logic sp, input logic [31:0] spd,
      input logic [34:0] ex);
    int n;
    bit ok;
    i_valid = 1; i_sign = s; i_exp = e; i_mant = m;
    i_special = sp; i_special_data = spd;
    n = 0;
    ok = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (o_ready) begin
        ok = 1;
        exp_q.push_back(ex);
      end
      @(posedge clk); #1;
      n++;
    end
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL send_timeout observed ready=0 expected accept");
    end
    i_valid = 0;
  endtask

  task automatic send_rand();
    logic s;
    logic [7:0] e;
    logic [27:0] m;
    logic sp;
    logic [31:0] spd;
    int pick;
    s    = 1'($urandom);
    pick = $urandom_range(0, 7);
    if (pick == 0) e = 8'($urandom_range(0, 3));
    else if (pick == 1) e = 8'($urandom_range(250, 254));
    else e = 8'($urandom_range(0, 254));
    m = 28'($urandom) >> $urandom_range(0, 27);
    if ($urandom_range(0, 15) == 0) m = 28'h0;
    sp  = ($urandom_range(0, 15) == 0);
    spd = $urandom;
    send_exp(s, e, m, sp, spd, model(s, e, m, sp, spd));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain observed %0d pending expected 0", exp_q.size());
    end
  endtask

  // scoreboard and stall-stability monitor
  always @(negedge clk) begin
    logic [34:0] e;
    if (!i_rst_n) begin
      stalled = 0;
    end else begin
      if (o_valid && !i_ready) begin
        if (stalled)
          chk("hold", {o_data, o_zero, o_overflow, o_underflow}, held);
        held    = {o_data, o_zero, o_overflow, o_underflow};
        stalled = 1;
      end else begin
        stalled = 0;
      end
      if (o_valid && i_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL extra_beat observed %h expected none", o_data);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("data", 35'(o_data), 35'(e[34:3]));
          chk("flags", 35'({o_zero, o_overflow, o_underflow}),
              35'(e[2:0]));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1; i_valid = 0; i_sign = 0; i_exp = 0; i_mant = 0;
    i_special = 0; i_special_data = 0; i_ready = 1;
    #2 i_rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 35'(o_valid), 35'(0));
    chk("rst_out", {o_data, o_zero, o_overflow, o_underflow}, 35'(0));
    i_rst_n = 1;
    @(posedge clk); #1;
    chk("rst_ready", 35'(o_ready), 35'(1));

    send_exp(0, 8'h7F, 28'h8000000, 0, 0, {32'h40000000, 3'b000});
    send_exp(0, 8'h80, 28'h1000000, 0, 0, {32'h3F000000, 3'b000});
    send_exp(0, 8'h7F, 28'h4000004, 0, 0, {32'h3F800000, 3'b000});
    send_exp(0, 8'h7F, 28'h400000C, 0, 0, {32'h3F800002, 3'b000});
    send_exp(1, 8'h7F, 28'h0, 0, 0, {32'h00000000, 3'b100});
    send_exp(1, 8'h01, 28'h2000000, 0, 0, {32'h80000000, 3'b101});
    send_exp(0, 8'hFE, 28'h8000000, 0, 0, {32'h7F800000, 3'b010});
    send_exp(0, 8'h7F, 28'h7FFFFFC, 0, 0, {32'h40000000, 3'b000});
    send_exp(1, 8'hFE, 28'h7FFFFFC, 0, 0, {32'hFF800000, 3'b010});
    send_exp(0, 8'h00, 28'h4000000, 0, 0, {32'h00000000, 3'b101});
    send_exp(1, 8'h05, 28'h8000000, 1, 32'h7FC00001,
             {32'h7FC00001, 3'b000});
    drain();

    fork
      begin
        for (int k = 0; k < 5; k++)
          send_exp(0, 8'(127 + k), 28'h4000000, 0, 0,
                   {32'(127 + k) << 23, 3'b000});
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        i_ready = 0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk("stall_ready", 35'(o_ready), 35'(0));
          chk("stall_valid", 35'(o_valid), 35'(1));
          @(posedge clk); #1;
        end
        i_ready = 1;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          chk("no_gap", 35'(o_valid), 35'(1));
          @(posedge clk); #1;
        end
      end
    join
    drain();

    i_ready = 0;
    send_exp(0, 8'h7F, 28'h8000000, 0, 0, {32'h40000000, 3'b000});
    send_exp(0, 8'h80, 28'h8000000, 0, 0, {32'h40800000, 3'b000});
    chk("inflight", 35'(o_valid), 35'(1));
    i_rst_n = 0;
    #1;
    chk("midrst_valid", 35'(o_valid), 35'(0));
    chk("midrst_out", {o_data, o_zero, o_overflow, o_underflow},
        35'(0));
    exp_q.delete();
    i_ready = 1;
    @(posedge clk);
    @(posedge clk); #1;
    i_rst_n = 1;
    @(posedge clk); #1;
    chk("midrst_ready", 35'(o_ready), 35'(1));
    send_exp(0, 8'h80, 28'h1000000, 0, 0, {32'h3F000000, 3'b000});
    chk("lat_1", 35'(o_valid), 35'(0));
    @(posedge clk); #1;
    chk("lat_2", 35'(o_valid), 35'(1));
    drain();

    done = 0;
    fork
      begin
        for (int k = 0; k < 300; k++) send_rand();
        done = 1;
      end
      begin
        while (!done) begin
          i_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        i_ready = 1;
      end
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_sub_normalize.md
# add_sub_normalize

Post-add normalize-and-round stage of the FP32 add/sub datapath. It takes the raw signed-magnitude mantissa sum and the larger operand's exponent, produced after exponent compare/align and the mantissa adder. It returns a packed IEEE-754 single-precision result rounded to nearest-even, with flush-to-zero. The block is a 2-stage pipeline with a valid/ready handshake and sits between the mantissa adder and the FFT butterfly result registers.

## Interface

Parameters:

- `EXP_W`, 8, exponent width.
- `FRAC_W`, 23, stored fraction width.
- `SUM_W`, 28, raw sum width. Bit layout:
  - `[27]` carry
  - `[26]` hidden
  - `[25:3]` fraction
  - `[2]` guard
  - `[1]` round
  - `[0]` sticky

Ports:

- `i_clk`, input, 1: clock.
- `i_rst_n`, input, 1: asynchronous active-low reset. There is one clock; reset is asynchronous and active-low.
- `i_valid`, input, 1: input beat valid.
- `o_ready`, output, 1: block can accept a beat.
- `i_sign`, input, 1: result sign from the adder.
- `i_exp`, input, `EXP_W`: biased exponent of the larger operand.
- `i_mant`, input, `SUM_W`: raw magnitude sum.
- `i_special`, input, 1: operand was Inf/NaN; `i_special_data` is forwarded unchanged.
- `i_special_data`, input, 32: pre-formed Inf/NaN word.
- `o_valid`, output, 1: result valid.
- `i_ready`, input, 1: downstream accepts.
- `o_data`, output, 32: packed FP32 result.
- `o_zero`, output, 1: result is ±0.
- `o_overflow`, output, 1: result saturated to ±Inf.
- `o_underflow`, output, 1: nonzero result flushed to ±0.

## Operation

- A beat is accepted when `i_valid & o_ready`. The output transfers when `o_valid & i_ready`.
- Stage 1 (normalize):
  - Carry set: shift right 1, OR the shifted-out bit into sticky, exponent +1.
  - Carry clear: `lzc` = leading zeros counted from bit 26 (0..26). Shift left by `lzc`; exponent −`lzc`.
  - Mantissa == 0: the zero path. Result is +0 (exact cancellation gives +0 under RNE), `o_zero`=1.
  - If `i_exp` ≤ `lzc` with a nonzero mantissa (flush-to-zero): result is `{i_sign, 31'b0}`, `o_underflow`=1, `o_zero`=1.
- Stage 2 (round, pack):
  - `round_up` = G & (R | S | lsb).
  - If the fraction+1 carries out, the fraction becomes 0 and the exponent +1.
  - Final exponent ≥ 255: output `{sign, 8'hFF, 23'b0}`, `o_overflow`=1.
- Exponent arithmetic is carried at `EXP_W`+2 bits signed so under/overflow is detected before truncation.
- When `i_special`=1, `o_data` = `i_special_data` and all flags are 0.
- Flags are mutually exclusive except `o_underflow` implies `o_zero`.

## Timing

- Latency: 2 cycles from an accepted beat to `o_valid`. Throughput: 1 beat per cycle.
- Global stall: `en` = `!o_valid | i_ready`, and `o_ready` = `en`.
- Both stage registers advance only when `en`=1. A stage-1 bubble is not collapsed.
- While `o_valid & !i_ready`:
  - `o_data` and all flags hold stable.
  - No beat is lost or duplicated.
  - Order is preserved.
- Reset (async assert, sync release):
  - Both stage valids = 0, so `o_valid`=0.
  - `o_data`=0 and all flags = 0.
  - `o_ready`=1 from the first clock after release.
- Reset mid-operation discards in-flight beats. No output is produced for them.
- Simultaneous input accept and output transfer in the same cycle is legal and required for full throughput.

## Structure

- Shared package `fpu_pkg`:
  - `EXP_W`, `FRAC_W`, `SUM_W`, `EXP_BIAS` (127), `EXP_MAX` (255).
  - Packed struct `fp32_t` {sign, exp, frac}.
  - Stage-1 payload struct.
- One sub-module: `add_sub_lzc_28bit`.
  - Combinational leading-zero count over bits `[26:0]`.
  - Built hierarchically from 4-bit LZC leaves with a valid/all-zero flag per leaf.
  - Output is 5-bit `o_count` plus `o_zero`.

## Test plan

- Carry normalize: `i_exp`=8'h7F, `i_mant`=28'h8000000 → 2 cycles later `o_data`=32'h40000000, all flags 0.
- Left normalize: `i_exp`=8'h80, `i_mant`=28'h1000000 → `o_data`=32'h3F000000.
- RNE ties, each with `i_exp`=8'h7F:
  - `i_mant`=28'h4000004 → 32'h3F800000.
  - `i_mant`=28'h400000C → 32'h3F800002.
- Zero, flush and overflow:
  - `i_mant`=0 → `o_data`=0, `o_zero`=1.
  - `i_exp`=8'h01, `i_mant`=28'h2000000, `i_sign`=1 → 32'h80000000, `o_underflow`=1.
  - `i_exp`=8'hFE, `i_mant`=28'h8000000 → 32'h7F800000, `o_overflow`=1.
- Backpressure: stream 5 back-to-back beats with `i_ready` held 0 for cycles 3..5.
  - `o_ready` drops the cycle after `o_valid` rises.
  - `o_data` stays stable while stalled.
  - All 5 results emerge in order with no gaps once `i_ready`=1.
- Reset mid-stream: assert `i_rst_n`=0 with two beats in flight → `o_valid`=0 immediately and `o_data`=0. After release, the next beat emerges with exactly 2-cycle latency.
